// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads INST_MEM combinationally and queues
// {PC, instruction} pairs in a small FIFO that decode drains over valid/ready.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic [31:0] PC,
  input  logic [31:0] INST_CODE,
  input  logic        FETCH_EN,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  output logic [31:0] INST_OUT,
  output logic [31:0] INST_PC,
  output logic        INST_VALID,
  input  logic        INST_READY,
  output logic        ALIGN_ERR
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic          align_err_q, align_err_d;
  logic [31:0]   buf_pc_q   [DEPTH];
  logic [31:0]   buf_pc_d   [DEPTH];
  logic [31:0]   buf_inst_q [DEPTH];
  logic [31:0]   buf_inst_d [DEPTH];
  logic          pop_s, push_s;

  // Handshake decode, pointer/count update, branch redirect and next state.
  always_comb begin
    pop_s       = (count_q != '0) && INST_READY && !BRANCH_TAKEN;
    push_s      = FETCH_EN && !BRANCH_TAKEN && (state_q != IDLE) &&
                  ((count_q < DEPTH_C) || pop_s);
    pc_d        = pc_q;
    count_d     = count_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    buf_pc_d    = buf_pc_q;
    buf_inst_d  = buf_inst_q;
    align_err_d = BRANCH_TAKEN && (BRANCH_TARGET[1:0] != 2'b00);
    state_d     = state_q;

    if (BRANCH_TAKEN) begin
      // Flush: pointers restart so the stale head is entry 0.
      pc_d    = {BRANCH_TARGET[31:2], 2'b00};
      count_d = '0;
      wptr_d  = '0;
      rptr_d  = '0;
    end else begin
      if (push_s) begin
        buf_pc_d[wptr_q]   = pc_q;
        buf_inst_d[wptr_q] = INST_CODE;
        pc_d               = pc_q + 32'd4;
        wptr_d             = wptr_q + PW'(1);
      end else begin
        pc_d = pc_q;
      end
      if (pop_s) begin
        rptr_d = rptr_q + PW'(1);
      end else begin
        rptr_d = rptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    if (BRANCH_TAKEN) begin
      state_d = FETCH_EN ? FETCH : IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = FETCH_EN ? FETCH : IDLE;
        FETCH: begin
          if (!FETCH_EN)                state_d = IDLE;
          else if (count_d == DEPTH_C)  state_d = FULL;
          else                          state_d = FETCH;
        end
        FULL: begin
          if (!FETCH_EN)                state_d = IDLE;
          else if (count_d < DEPTH_C)   state_d = FETCH;
          else                          state_d = FULL;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, PC, pointers and buffer storage.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      count_q     <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      align_err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_pc_q[i]   <= 32'h0000_0000;
        buf_inst_q[i] <= 32'h0000_0000;
      end
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      count_q     <= count_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      align_err_q <= align_err_d;
      for (int i = 0; i < DEPTH; i++) begin
        buf_pc_q[i]   <= buf_pc_d[i];
        buf_inst_q[i] <= buf_inst_d[i];
      end
    end
  end

  assign PC         = pc_q;
  assign INST_OUT   = buf_inst_q[rptr_q];
  assign INST_PC    = buf_pc_q[rptr_q];
  assign INST_VALID = (count_q != '0);
  assign ALIGN_ERR  = align_err_q;

endmodule
